mac_seq: RTL and testbench

Sequencer that drives the 16-bit pipelined MAC from the initiator side for one fully connected layer. For each of NUM_NEURONS neurons it streams a VEC_LEN-element input vector and that neuron's weight row into the MAC, one element per cycle, marking each set with a start pulse. It collects each finished dot product from the MAC's done pulse and publishes it as an indexed result. It sits between the layer controller and the input/weight memories on one side and a MAC instance on the other.

---
 rtl/mac_seq_pkg.sv | 26 ++
 rtl/mac_seq_if.sv | 49 ++++
 rtl/mac_seq_addr_gen.sv | 65 ++++++
 rtl/mac_seq.sv | 130 +++++++++++++
 tb/tb_mac_seq.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// mac_seq_pkg
// Shared definitions for the MAC sequencer: the sequencer state encoding, the
// default data width, the MAC pipeline latency and an address-width helper.
// -----------------------------------------------------------------------------
package mac_seq_pkg;

    localparam int DEF_DATA_W = 16;

    // Cycles from a mac_start on the MAC inputs to the matching mac_done.
    localparam int MAC_LAT = 6;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DRAIN
    } state_t;

    // Width of an index over n items. Returns at least 1 so that a
    // single-entry range still gets a real (constant zero) bus.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_seq_if.sv
// -----------------------------------------------------------------------------
// mac_seq_if
// Bundles every non-clock/reset signal of the sequencer.
//   control : go (in), busy / finished (out)
//   memories: in_addr / w_addr (out), in_data / w_data (in, 1-cycle read)
//   MAC     : mac_start / mac_in / mac_weight (out), mac_done / mac_out (in)
//   results : res_valid / res_idx / res_data (out)
// master = the sequencer, slave = its environment (controller, memories, MAC).
// -----------------------------------------------------------------------------
interface mac_seq_if
    import mac_seq_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int VEC_LEN     = 4,
    parameter int NUM_NEURONS = 4
);
    localparam int IN_AW = addr_w(VEC_LEN);
    localparam int W_AW  = addr_w(VEC_LEN * NUM_NEURONS);
    localparam int IDX_W = addr_w(NUM_NEURONS);

    logic              go;
    logic              busy;
    logic              finished;
    logic [IN_AW-1:0]  in_addr;
    logic [DATA_W-1:0] in_data;
    logic [W_AW-1:0]   w_addr;
    logic [DATA_W-1:0] w_data;
    logic              mac_start;
    logic [DATA_W-1:0] mac_in;
    logic [DATA_W-1:0] mac_weight;
    logic              mac_done;
    logic [DATA_W-1:0] mac_out;
    logic              res_valid;
    logic [IDX_W-1:0]  res_idx;
    logic [DATA_W-1:0] res_data;

    modport master (
        input  go, in_data, w_data, mac_done, mac_out,
        output busy, finished, in_addr, w_addr, mac_start, mac_in, mac_weight,
               res_valid, res_idx, res_data
    );

    modport slave (
        output go, in_data, w_data, mac_done, mac_out,
        input  busy, finished, in_addr, w_addr, mac_start, mac_in, mac_weight,
               res_valid, res_idx, res_data
    );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// -----------------------------------------------------------------------------
// mac_seq_addr_gen
// Element (e) and neuron (n) counters for the stream phase.
//   clk, reset : clock, asynchronous active-high reset
//   step       : advance to the next address pair
//   in_addr    : e, input-vector address
//   w_addr     : n*VEC_LEN + e, weight address (kept as a running count)
//   first      : current element is e == 0 (start of a set)
//   last       : current pair is the final one (n = N-1, e = L-1)
// All counters wrap back to zero after the last pair, ready for the next run.
// -----------------------------------------------------------------------------
module mac_seq_addr_gen
    import mac_seq_pkg::*;
#(
    parameter int VEC_LEN     = 4,
    parameter int NUM_NEURONS = 4,
    parameter int IN_AW       = addr_w(VEC_LEN),
    parameter int W_AW        = addr_w(VEC_LEN * NUM_NEURONS),
    parameter int IDX_W       = addr_w(NUM_NEURONS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [IN_AW-1:0] in_addr,
    output logic [W_AW-1:0]  w_addr,
    output logic             first,
    output logic             last
);
    localparam logic [IN_AW-1:0] E_LAST = IN_AW'(VEC_LEN - 1);
    localparam logic [IDX_W-1:0] N_LAST = IDX_W'(NUM_NEURONS - 1);

    logic [IN_AW-1:0] e;
    logic [IDX_W-1:0] n;
    logic [W_AW-1:0]  w;

    assign in_addr = e;
    assign w_addr  = w;
    assign first   = (e == '0);
    assign last    = (e == E_LAST) && (n == N_LAST);

    // NOTE: registers are assigned with <= so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e <= '0;
            n <= '0;
            w <= '0;
        end else if (step) begin
            if (last) begin
                e <= '0;
                n <= '0;
                w <= '0;
            end else begin
                w <= w + W_AW'(1);
                if (e == E_LAST) begin
                    e <= '0;
                    n <= n + IDX_W'(1);
                end else begin
                    e <= e + IN_AW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mac_seq.sv
// -----------------------------------------------------------------------------
// mac_seq
// Drives a pipelined MAC for one fully connected layer: streams VEC_LEN input
// elements with each of NUM_NEURONS weight rows, appends one zero flush set,
// and publishes every completed dot product as (res_idx, res_data).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mac_seq_if.master (control, memory, MAC and result signals)
// -----------------------------------------------------------------------------
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int VEC_LEN     = 4,
    parameter int NUM_NEURONS = 4
) (
    input  logic      clk,
    input  logic      reset,
    mac_seq_if.master bus
);
    localparam int IN_AW = addr_w(VEC_LEN);
    localparam int W_AW  = addr_w(VEC_LEN * NUM_NEURONS);
    localparam int IDX_W = addr_w(NUM_NEURONS);
    localparam int CNT_W = $clog2(NUM_NEURONS + 1);
    // The MAC reports a set's sum on the done pulse of the following set, so
    // N neurons plus the flush yield N+1 pulses, numbered 0..N.
    localparam logic [CNT_W-1:0] LAST_DONE = CNT_W'(NUM_NEURONS);

    state_t           state, state_nx;
    logic             step, flush_slot;
    logic             first, last;
    logic [IN_AW-1:0] in_addr;
    logic [W_AW-1:0]  w_addr;
    logic             slot_vld, slot_first, slot_flush;
    logic [CNT_W-1:0] done_cnt;
    logic             run_done;

    mac_seq_addr_gen #(
        .VEC_LEN     (VEC_LEN),
        .NUM_NEURONS (NUM_NEURONS)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .step    (step),
        .in_addr (in_addr),
        .w_addr  (w_addr),
        .first   (first),
        .last    (last)
    );

    assign bus.in_addr = in_addr;
    assign bus.w_addr  = w_addr;
    assign bus.busy    = (state != IDLE);
    assign run_done    = (state == DRAIN) && bus.mac_done && (done_cnt == LAST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        step       = 1'b0;
        flush_slot = 1'b0;
        case (state)
            IDLE:   if (bus.go) state_nx = STREAM;
            STREAM: begin
                step = 1'b1;
                if (last) state_nx = FLUSH;
            end
            FLUSH:  begin
                flush_slot = 1'b1;
                state_nx   = DRAIN;
            end
            DRAIN:  if (run_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Two-stage MAC drive: the slot_* flags follow the address by one cycle to
    // meet the memory read data, then everything is registered onto mac_*.
    // The flush slot rides the same pipe with its operands forced to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_vld       <= 1'b0;
            slot_first     <= 1'b0;
            slot_flush     <= 1'b0;
            bus.mac_start  <= 1'b0;
            bus.mac_in     <= '0;
            bus.mac_weight <= '0;
        end else begin
            slot_vld       <= step | flush_slot;
            slot_first     <= (step & first) | flush_slot;
            slot_flush     <= flush_slot;
            bus.mac_start  <= slot_first;
            bus.mac_in     <= (slot_vld && !slot_flush) ? bus.in_data : '0;
            bus.mac_weight <= (slot_vld && !slot_flush) ? bus.w_data  : '0;
        end
    end

    // Result capture. Pulse 0 belongs to the set before neuron 0 and is
    // dropped; pulse k carries neuron k-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_cnt      <= '0;
            bus.res_valid <= 1'b0;
            bus.res_idx   <= '0;
            bus.res_data  <= '0;
            bus.finished  <= 1'b0;
        end else begin
            bus.res_valid <= 1'b0;
            bus.finished  <= 1'b0;
            if ((state != IDLE) && bus.mac_done) begin
                if (done_cnt != '0) begin
                    bus.res_valid <= 1'b1;
                    bus.res_idx   <= IDX_W'(done_cnt - CNT_W'(1));
                    bus.res_data  <= bus.mac_out;
                end
                if (run_done) begin
                    done_cnt     <= '0;
                    bus.finished <= 1'b1;
                end else begin
                    done_cnt <= done_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_seq
// Three sequencer instances (L=4/N=2, L=1/N=1, L=1/N=3), each with registered
// input/weight memories and a behavioural pipelined MAC: mac_done follows each
// sampled mac_start by MAC_LAT cycles and carries the sum of the preceding set.
// -----------------------------------------------------------------------------
module tb_mac_seq;
    import mac_seq_pkg::*;

    localparam int DW = 16;
    localparam int LOG_N = 40;

    localparam logic [DW-1:0] IN_VEC [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    localparam logic [DW-1:0] W_ROWS [8] = '{16'd1, 16'd1, 16'd1, 16'd1,
                                             16'd2, 16'd0, 16'd1, 16'd0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: L=4, N=2 ----------------
    mac_seq_if #(.DATA_W(DW), .VEC_LEN(4), .NUM_NEURONS(2)) bus_a ();
    mac_seq #(.DATA_W(DW), .VEC_LEN(4), .NUM_NEURONS(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));

    logic [DW-1:0] a_in [4];
    logic [DW-1:0] a_w  [8];
    always @(posedge clk) begin
        bus_a.in_data <= a_in[bus_a.in_addr];
        bus_a.w_data  <= a_w[bus_a.w_addr];
    end

    logic [MAC_LAT-1:0] a_dly;
    logic [DW-1:0]      a_pipe [MAC_LAT];
    logic [DW-1:0]      a_acc, a_prod;
    logic               a_inj = 1'b0;
    assign a_prod = bus_a.mac_in * bus_a.mac_weight;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_dly <= '0;
            a_acc <= '0;
            for (int i = 0; i < MAC_LAT; i++) a_pipe[i] <= '0;
        end else begin
            a_dly     <= {a_dly[MAC_LAT-2:0], bus_a.mac_start};
            a_pipe[0] <= a_acc;
            for (int i = 1; i < MAC_LAT; i++) a_pipe[i] <= a_pipe[i-1];
            a_acc <= bus_a.mac_start ? a_prod : a_acc + a_prod;
        end
    end
    assign bus_a.mac_done = a_dly[MAC_LAT-1] | a_inj;
    assign bus_a.mac_out  = a_pipe[MAC_LAT-1];

    // ---------------- instance B: L=1, N=1 ----------------
    mac_seq_if #(.DATA_W(DW), .VEC_LEN(1), .NUM_NEURONS(1)) bus_b ();
    mac_seq #(.DATA_W(DW), .VEC_LEN(1), .NUM_NEURONS(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    logic [DW-1:0] b_in [2];
    logic [DW-1:0] b_w  [2];
    always @(posedge clk) begin
        bus_b.in_data <= b_in[bus_b.in_addr];
        bus_b.w_data  <= b_w[bus_b.w_addr];
    end

    logic [MAC_LAT-1:0] b_dly;
    logic [DW-1:0]      b_pipe [MAC_LAT];
    logic [DW-1:0]      b_acc, b_prod;
    assign b_prod = bus_b.mac_in * bus_b.mac_weight;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            b_dly <= '0;
            b_acc <= '0;
            for (int i = 0; i < MAC_LAT; i++) b_pipe[i] <= '0;
        end else begin
            b_dly     <= {b_dly[MAC_LAT-2:0], bus_b.mac_start};
            b_pipe[0] <= b_acc;
            for (int i = 1; i < MAC_LAT; i++) b_pipe[i] <= b_pipe[i-1];
            b_acc <= bus_b.mac_start ? b_prod : b_acc + b_prod;
        end
    end
    assign bus_b.mac_done = b_dly[MAC_LAT-1];
    assign bus_b.mac_out  = b_pipe[MAC_LAT-1];

    // ---------------- instance C: L=1, N=3 ----------------
    mac_seq_if #(.DATA_W(DW), .VEC_LEN(1), .NUM_NEURONS(3)) bus_c ();
    mac_seq #(.DATA_W(DW), .VEC_LEN(1), .NUM_NEURONS(3)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c));

    logic [DW-1:0] c_in [2];
    logic [DW-1:0] c_w  [4];
    always @(posedge clk) begin
        bus_c.in_data <= c_in[bus_c.in_addr];
        bus_c.w_data  <= c_w[bus_c.w_addr];
    end

    logic [MAC_LAT-1:0] c_dly;
    logic [DW-1:0]      c_pipe [MAC_LAT];
    logic [DW-1:0]      c_acc, c_prod;
    assign c_prod = bus_c.mac_in * bus_c.mac_weight;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            c_dly <= '0;
            c_acc <= '0;
            for (int i = 0; i < MAC_LAT; i++) c_pipe[i] <= '0;
        end else begin
            c_dly     <= {c_dly[MAC_LAT-2:0], bus_c.mac_start};
            c_pipe[0] <= c_acc;
            for (int i = 1; i < MAC_LAT; i++) c_pipe[i] <= c_pipe[i-1];
            c_acc <= bus_c.mac_start ? c_prod : c_acc + c_prod;
        end
    end
    assign bus_c.mac_done = c_dly[MAC_LAT-1];
    assign bus_c.mac_out  = c_pipe[MAC_LAT-1];

    // ---------------- per-cycle log of instance A ----------------
    // Entry c is sampled 1 time unit after edge E(c), E0 being the go edge.
    logic          lg_start [LOG_N];
    logic [DW-1:0] lg_in    [LOG_N];
    logic [DW-1:0] lg_w     [LOG_N];
    logic          lg_busy  [LOG_N];
    logic          lg_valid [LOG_N];
    logic          lg_fin   [LOG_N];
    logic [0:0]    lg_idx   [LOG_N];
    logic [DW-1:0] lg_data  [LOG_N];
    logic [1:0]    lg_ia    [LOG_N];
    logic [2:0]    lg_wa    [LOG_N];

    // Starts a run on A and logs LOG_N cycles; go is raised again after the
    // sample at cycle go_again (-1 for never), i.e. it is seen at E(go_again+1).
    task automatic run_a(input int go_again);
        @(negedge clk);
        bus_a.go = 1'b1;
        @(posedge clk);
        for (int c = 0; c < LOG_N; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            lg_start[c] = bus_a.mac_start;
            lg_in[c]    = bus_a.mac_in;
            lg_w[c]     = bus_a.mac_weight;
            lg_busy[c]  = bus_a.busy;
            lg_valid[c] = bus_a.res_valid;
            lg_fin[c]   = bus_a.finished;
            lg_idx[c]   = bus_a.res_idx;
            lg_data[c]  = bus_a.res_data;
            lg_ia[c]    = bus_a.in_addr;
            lg_wa[c]    = bus_a.w_addr;
            bus_a.go    = (c == go_again);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({bus_a.busy, bus_a.finished, bus_a.in_addr, bus_a.w_addr, bus_a.mac_start,
             bus_a.mac_in, bus_a.mac_weight, bus_a.res_valid, bus_a.res_idx,
             bus_a.res_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_a got busy=%0b fin=%0b ia=%0d wa=%0d st=%0b in=%h w=%h rv=%0b ri=%0d rd=%h exp all 0",
                     bus_a.busy, bus_a.finished, bus_a.in_addr, bus_a.w_addr, bus_a.mac_start,
                     bus_a.mac_in, bus_a.mac_weight, bus_a.res_valid, bus_a.res_idx, bus_a.res_data);
        end
        checks++;
        if ({bus_b.busy, bus_c.busy, bus_b.res_valid, bus_c.res_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs_bc got %b exp 0000",
                     {bus_b.busy, bus_c.busy, bus_b.res_valid, bus_c.res_valid});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic          exp_s;
        logic [DW-1:0] exp_i, exp_w;
        int            pulses;
        run_a(-1);
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            exp_s = (c == 2) || (c == 6) || (c == 10);
            exp_i = (c >= 2 && c <= 9) ? IN_VEC[(c - 2) % 4] : '0;
            exp_w = (c >= 2 && c <= 9) ? W_ROWS[c - 2] : '0;
            checks++;
            if (lg_start[c] !== exp_s) begin
                errors++;
                $display("FAIL basic_mac_start c=%0d got %0b exp %0b", c, lg_start[c], exp_s);
            end
            checks++;
            if ({lg_in[c], lg_w[c]} !== {exp_i, exp_w}) begin
                errors++;
                $display("FAIL basic_mac_operands c=%0d got in=%0d w=%0d exp in=%0d w=%0d",
                         c, lg_in[c], lg_w[c], exp_i, exp_w);
            end
            checks++;
            if (lg_busy[c] !== (c < 17)) begin
                errors++;
                $display("FAIL basic_busy c=%0d got %0b exp %0b", c, lg_busy[c], c < 17);
            end
            checks++;
            if ({lg_valid[c], lg_fin[c]} !== {(c == 13) || (c == 17), c == 17}) begin
                errors++;
                $display("FAIL basic_valid_finished c=%0d got %0b%0b exp %0b%0b", c,
                         lg_valid[c], lg_fin[c], (c == 13) || (c == 17), c == 17);
            end
            if (c <= 8) begin
                checks++;
                if ({lg_ia[c], lg_wa[c]} !== {2'(c % 4), 3'(c % 8)}) begin
                    errors++;
                    $display("FAIL basic_addr c=%0d got in_addr=%0d w_addr=%0d exp %0d %0d",
                             c, lg_ia[c], lg_wa[c], c % 4, c % 8);
                end
            end
            if (lg_valid[c] === 1'b1) pulses++;
        end
        checks++;
        if ({lg_idx[13], lg_data[13]} !== {1'b0, 16'd10}) begin
            errors++;
            $display("FAIL basic_res0 got idx=%0d data=%0d exp idx=0 data=10", lg_idx[13], lg_data[13]);
        end
        checks++;
        if ({lg_idx[17], lg_data[17]} !== {1'b1, 16'd5}) begin
            errors++;
            $display("FAIL basic_res1 got idx=%0d data=%0d exp idx=1 data=5", lg_idx[17], lg_data[17]);
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL basic_pulse_count got %0d exp 2", pulses);
        end
    endtask

    task automatic test_ignore();
        // mac_done while idle must not advance the result counter.
        @(negedge clk);
        a_inj = 1'b1;
        @(negedge clk);
        a_inj = 1'b0;
        checks++;
        if ({bus_a.busy, bus_a.res_valid} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_idle_done got busy=%0b rv=%0b exp 0 0", bus_a.busy, bus_a.res_valid);
        end
        // go pulsed again while streaming (seen at E4).
        run_a(3);
        checks++;
        if ({lg_valid[13], lg_idx[13], lg_data[13]} !== {1'b1, 1'b0, 16'd10}) begin
            errors++;
            $display("FAIL ignore_res0 got v=%0b idx=%0d data=%0d exp v=1 idx=0 data=10",
                     lg_valid[13], lg_idx[13], lg_data[13]);
        end
        checks++;
        if ({lg_valid[17], lg_idx[17], lg_data[17], lg_fin[17]} !== {1'b1, 1'b1, 16'd5, 1'b1}) begin
            errors++;
            $display("FAIL ignore_res1 got v=%0b idx=%0d data=%0d fin=%0b exp v=1 idx=1 data=5 fin=1",
                     lg_valid[17], lg_idx[17], lg_data[17], lg_fin[17]);
        end
        for (int c = 18; c < LOG_N; c++) begin
            checks++;
            if ({lg_busy[c], lg_start[c], lg_valid[c]} !== 3'b000) begin
                errors++;
                $display("FAIL ignore_no_restart c=%0d got busy=%0b st=%0b rv=%0b exp 0 0 0",
                         c, lg_busy[c], lg_start[c], lg_valid[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // New go presented in the cycle after finished (seen at E18).
        run_a(17);
        checks++;
        if ({lg_fin[17], lg_busy[17], lg_busy[18]} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_accept got fin17=%0b busy17=%0b busy18=%0b exp 1 0 1",
                     lg_fin[17], lg_busy[17], lg_busy[18]);
        end
        checks++;
        if ({lg_start[20], lg_in[20], lg_w[20]} !== {1'b1, 16'd1, 16'd1}) begin
            errors++;
            $display("FAIL b2b_first_elem got st=%0b in=%0d w=%0d exp 1 1 1",
                     lg_start[20], lg_in[20], lg_w[20]);
        end
        checks++;
        if ({lg_valid[31], lg_idx[31], lg_data[31]} !== {1'b1, 1'b0, 16'd10}) begin
            errors++;
            $display("FAIL b2b_res0 got v=%0b idx=%0d data=%0d exp v=1 idx=0 data=10",
                     lg_valid[31], lg_idx[31], lg_data[31]);
        end
        checks++;
        if ({lg_valid[35], lg_idx[35], lg_data[35], lg_fin[35], lg_busy[35]} !==
            {1'b1, 1'b1, 16'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_res1 got v=%0b idx=%0d data=%0d fin=%0b busy=%0b exp 1 1 5 1 0",
                     lg_valid[35], lg_idx[35], lg_data[35], lg_fin[35], lg_busy[35]);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        bus_a.go = 1'b1;
        @(posedge clk);
        #1;
        bus_a.go = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_a.busy, bus_a.finished, bus_a.in_addr, bus_a.w_addr, bus_a.mac_start,
             bus_a.mac_in, bus_a.mac_weight, bus_a.res_valid, bus_a.res_idx,
             bus_a.res_data} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%0b ia=%0d wa=%0d st=%0b in=%h w=%h rv=%0b ri=%0d rd=%h exp all 0",
                     bus_a.busy, bus_a.in_addr, bus_a.w_addr, bus_a.mac_start, bus_a.mac_in,
                     bus_a.mac_weight, bus_a.res_valid, bus_a.res_idx, bus_a.res_data);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_a.busy, bus_a.res_valid, bus_a.finished} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_stale c=%0d got busy=%0b rv=%0b fin=%0b exp 0 0 0",
                         c, bus_a.busy, bus_a.res_valid, bus_a.finished);
            end
        end
        run_a(-1);
        pulses = 0;
        for (int c = 0; c < LOG_N; c++) if (lg_valid[c] === 1'b1) pulses++;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL midreset_pulse_count got %0d exp 2", pulses);
        end
        checks++;
        if ({lg_valid[13], lg_data[13], lg_valid[17], lg_data[17]} !==
            {1'b1, 16'd10, 1'b1, 16'd5}) begin
            errors++;
            $display("FAIL midreset_results got v13=%0b d13=%0d v17=%0b d17=%0d exp 1 10 1 5",
                     lg_valid[13], lg_data[13], lg_valid[17], lg_data[17]);
        end
    endtask

    task automatic test_wrap();
        b_in[0] = 16'h8000;
        b_in[1] = 16'h0000;
        b_w[0]  = 16'd2;
        b_w[1]  = 16'd0;
        @(negedge clk);
        bus_b.go = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            bus_b.go = 1'b0;
            if (c == 2) begin
                checks++;
                if ({bus_b.mac_start, bus_b.mac_in, bus_b.mac_weight} !== {1'b1, 16'h8000, 16'd2}) begin
                    errors++;
                    $display("FAIL wrap_elem got st=%0b in=%h w=%h exp 1 8000 0002",
                             bus_b.mac_start, bus_b.mac_in, bus_b.mac_weight);
                end
            end
            if (c == 3) begin
                checks++;
                if ({bus_b.mac_start, bus_b.mac_in, bus_b.mac_weight} !== {1'b1, 16'h0, 16'h0}) begin
                    errors++;
                    $display("FAIL wrap_flush got st=%0b in=%h w=%h exp 1 0000 0000",
                             bus_b.mac_start, bus_b.mac_in, bus_b.mac_weight);
                end
            end
            checks++;
            if ({bus_b.res_valid, bus_b.finished, bus_b.busy} !== {c == 10, c == 10, c < 10}) begin
                errors++;
                $display("FAIL wrap_ctrl c=%0d got rv=%0b fin=%0b busy=%0b exp %0b %0b %0b", c,
                         bus_b.res_valid, bus_b.finished, bus_b.busy, c == 10, c == 10, c < 10);
            end
            if (c == 10) begin
                checks++;
                if ({bus_b.res_idx, bus_b.res_data} !== {1'b0, 16'h0000}) begin
                    errors++;
                    $display("FAIL wrap_result got idx=%0d data=%h exp idx=0 data=0000",
                             bus_b.res_idx, bus_b.res_data);
                end
            end
        end
    endtask

    task automatic test_vec1();
        logic [DW-1:0] exp_w;
        c_in[0] = 16'd2;
        c_in[1] = 16'd0;
        c_w[0]  = 16'd3;
        c_w[1]  = 16'd4;
        c_w[2]  = 16'd5;
        c_w[3]  = 16'd0;
        @(negedge clk);
        bus_c.go = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 18; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            bus_c.go = 1'b0;
            case (c)
                2:       exp_w = 16'd3;
                3:       exp_w = 16'd4;
                4:       exp_w = 16'd5;
                default: exp_w = 16'd0;
            endcase
            checks++;
            if ({bus_c.mac_start, bus_c.mac_in, bus_c.mac_weight} !==
                {(c >= 2) && (c <= 5), (c >= 2 && c <= 4) ? 16'd2 : 16'd0, exp_w}) begin
                errors++;
                $display("FAIL vec1_mac c=%0d got st=%0b in=%0d w=%0d", c,
                         bus_c.mac_start, bus_c.mac_in, bus_c.mac_weight);
            end
            checks++;
            if ({bus_c.res_valid, bus_c.finished, bus_c.busy} !==
                {(c >= 10) && (c <= 12), c == 12, c < 12}) begin
                errors++;
                $display("FAIL vec1_ctrl c=%0d got rv=%0b fin=%0b busy=%0b exp %0b %0b %0b", c,
                         bus_c.res_valid, bus_c.finished, bus_c.busy,
                         (c >= 10) && (c <= 12), c == 12, c < 12);
            end
            if (c >= 10 && c <= 12) begin
                checks++;
                if ({bus_c.res_idx, bus_c.res_data} !== {2'(c - 10), 16'(6 + 2 * (c - 10))}) begin
                    errors++;
                    $display("FAIL vec1_result c=%0d got idx=%0d data=%0d exp idx=%0d data=%0d",
                             c, bus_c.res_idx, bus_c.res_data, c - 10, 6 + 2 * (c - 10));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.go = 1'b0;
        bus_b.go = 1'b0;
        bus_c.go = 1'b0;
        for (int i = 0; i < 4; i++) a_in[i] = IN_VEC[i];
        for (int i = 0; i < 8; i++) a_w[i] = W_ROWS[i];
        b_in[0] = '0; b_in[1] = '0; b_w[0] = '0; b_w[1] = '0;
        for (int i = 0; i < 2; i++) c_in[i] = '0;
        for (int i = 0; i < 4; i++) c_w[i] = '0;

        test_reset();
        test_basic();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_vec1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
